mult_sweep_checker: RTL and testbench

- Hardware counterpart of the exhaustive multiplier bench: this block generates every operand pair for a combinational signed approximate multiplier (e.g. the 8x8 carry-aware family), reads back its product, and accumulates error statistics against an internal exact product.
- Sits beside the multiplier under test in the FPGA evaluation wrapper, so full-range error metrics come out without simulation.

---
 rtl/mult_sweep_checker.sv | 97 +++++++++
 tb/tb_mult_sweep_checker.sv | 110 +++++++++++
 2 files changed

// File: rtl/mult_sweep_checker.sv
// mult_sweep_checker: exhaustive signed operand sweep that accumulates error statistics of an approximate multiplier
module mult_sweep_checker #(
  parameter int W = 8,
  parameter int ACC_W = 4*W+1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [W-1:0]     a_out,
  output logic [W-1:0]     b_out,
  input  logic [2*W-1:0]   p_in,
  output logic             busy,
  output logic             done,
  output logic [2*W:0]     err_count,
  output logic [ACC_W-1:0] abs_err_sum,
  output logic [ACC_W-1:0] err_sum,
  output logic [2*W:0]     max_abs_err,
  output logic [W-1:0]     worst_a,
  output logic [W-1:0]     worst_b
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic accept, last, valid_q, valid_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, sa_q, sa_d, sb_q, sb_d, wa_q, wa_d, wb_q, wb_d;
  logic signed [2*W-1:0] prod;
  logic signed [2*W:0] err_q, err_d;
  logic [2*W:0] abs_q, abs_d, cnt_q, cnt_d, max_q, max_d;
  logic [ACC_W-1:0] asum_q, asum_d, esum_q, esum_d;
  logic upd;
  assign accept = start && (state_q == IDLE || state_q == DONE);
  assign last = &{a_q, b_q};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      sa_q <= '0;
      sb_q <= '0;
      wa_q <= '0;
      wb_q <= '0;
      err_q <= '0;
      abs_q <= '0;
      cnt_q <= '0;
      max_q <= '0;
      asum_q <= '0;
      esum_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      a_q <= a_d;
      b_q <= b_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      wa_q <= wa_d;
      wb_q <= wb_d;
      err_q <= err_d;
      abs_q <= abs_d;
      cnt_q <= cnt_d;
      max_q <= max_d;
      asum_q <= asum_d;
      esum_q <= esum_d;
    end
  end
  always_comb begin
    state_d = accept ? RUN : (state_q == RUN && last) ? DRAIN : (state_q == DRAIN) ? DONE : state_q;
  end
  always_comb begin
    busy = state_q == RUN || state_q == DRAIN;
    done = state_q == DONE;
  end
  always_comb begin
    prod = $signed(a_q) * $signed(b_q);
    err_d = $signed({p_in[2*W-1], p_in}) - $signed({prod[2*W-1], prod});
    abs_d = err_d[2*W] ? -err_d : err_d;
    sa_d = a_q;
    sb_d = b_q;
    valid_d = state_q == RUN;
    a_d = accept ? '0 : (state_q == RUN && !last) ? a_q + 1'b1 : a_q;
    b_d = accept ? '0 : (state_q == RUN && !last && &a_q) ? b_q + 1'b1 : b_q;
    upd = valid_q && abs_q > max_q;
    cnt_d = accept ? '0 : cnt_q + {{(2*W){1'b0}}, valid_q && err_q != '0};
    asum_d = accept ? '0 : valid_q ? asum_q + {{(ACC_W-2*W-1){1'b0}}, abs_q} : asum_q;
    esum_d = accept ? '0 : valid_q ? esum_q + {{(ACC_W-2*W-1){err_q[2*W]}}, err_q} : esum_q;
    max_d = accept ? '0 : upd ? abs_q : max_q;
    wa_d = accept ? '0 : upd ? sa_q : wa_q;
    wb_d = accept ? '0 : upd ? sb_q : wb_q;
  end
  assign a_out = a_q;
  assign b_out = b_q;
  assign err_count = cnt_q;
  assign abs_err_sum = asum_q;
  assign err_sum = esum_q;
  assign max_abs_err = max_q;
  assign worst_a = wa_q;
  assign worst_b = wb_q;
endmodule

// File: tb/tb_mult_sweep_checker.sv
// tb_mult_sweep_checker: directed sweeps of a 4-bit checker against small multiplier models
module tb_mult_sweep_checker;
  localparam int W = 4;
  localparam int ACC_W = 4*W+1;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] a_out, b_out, worst_a, worst_b;
  logic [2*W-1:0] p_in;
  logic busy, done;
  logic [2*W:0] err_count, max_abs_err;
  logic [ACC_W-1:0] abs_err_sum, err_sum;
  logic signed [2*W-1:0] exact;
  int mode = 0;
  int errors = 0;
  int checks = 0;
  int cyc;
  mult_sweep_checker #(.W(W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .a_out(a_out), .b_out(b_out), .p_in(p_in),
    .busy(busy), .done(done), .err_count(err_count), .abs_err_sum(abs_err_sum),
    .err_sum(err_sum), .max_abs_err(max_abs_err), .worst_a(worst_a), .worst_b(worst_b)
  );
  always #5 clk = ~clk;
  always_comb begin
    exact = $signed(a_out) * $signed(b_out);
    p_in = exact;
    if (mode == 1) p_in = exact + 8'sd1;
    if (mode == 2 && a_out == 4'hB && b_out == 4'h3) p_in = exact - 8'sd5;
    if (mode == 2 && a_out == 4'hD && b_out == 4'h3) p_in = exact + 8'sd5;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_stats(input string tag, input int cnt, input int asum, input int esum, input int mx, input int wa, input int wb);
    chk({tag, ".err_count"}, 64'(err_count), 64'(cnt));
    chk({tag, ".abs_err_sum"}, 64'(abs_err_sum), 64'(asum));
    chk({tag, ".err_sum"}, 64'($signed(err_sum)), 64'(esum));
    chk({tag, ".max_abs_err"}, 64'(max_abs_err), 64'(mx));
    chk({tag, ".worst_a"}, 64'(worst_a), 64'(wa));
    chk({tag, ".worst_b"}, 64'(worst_b), 64'(wb));
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, ".a_out"}, 64'(a_out), 64'd0);
    chk({tag, ".b_out"}, 64'(b_out), 64'd0);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".done"}, 64'(done), 64'd0);
    chk_stats(tag, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic sweep(input string tag, input bit order, input bit repulse, input int abort_at);
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    chk({tag, ".done_drop"}, 64'(done), 64'd0);
    chk({tag, ".busy"}, 64'(busy), 64'd1);
    chk({tag, ".clear_cnt"}, 64'(err_count), 64'd0);
    chk({tag, ".clear_max"}, 64'(max_abs_err), 64'd0);
    while (!done && cyc < 400) begin
      if (order && cyc == 1) chk("order.v1", 64'({a_out, b_out}), 64'h00);
      if (order && cyc == 2) chk("order.v2", 64'({a_out, b_out}), 64'h10);
      if (order && cyc == 16) chk("order.v16", 64'({a_out, b_out}), 64'hF0);
      if (order && cyc == 17) chk("order.v17", 64'({a_out, b_out}), 64'h01);
      if (order && cyc == 256) chk("order.last", 64'({a_out, b_out}), 64'hFF);
      if (order && cyc == 257) chk("order.drain_busy", 64'(busy), 64'd1);
      if (cyc == abort_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        return;
      end
      if (repulse && cyc == 10) start = 1'b1;
      step();
      start = 1'b0;
      cyc++;
    end
    chk({tag, ".latency"}, 64'(cyc), 64'd258);
    chk({tag, ".busy_done"}, 64'(busy), 64'd0);
  endtask
  initial begin
    step();
    step();
    rst = 1'b0;
    chk_zero("reset");
    mode = 0;
    sweep("exact", 1'b1, 1'b1, 0);
    chk_stats("exact", 0, 0, 0, 0, 0, 0);
    chk("exact.hold_ab", 64'({a_out, b_out}), 64'hFF);
    mode = 1;
    sweep("plus1", 1'b0, 1'b0, 0);
    chk_stats("plus1", 256, 256, 256, 1, 0, 0);
    mode = 2;
    sweep("pair", 1'b0, 1'b0, 0);
    chk_stats("pair", 2, 10, 0, 5, 'hB, 'h3);
    mode = 1;
    sweep("abort", 1'b0, 1'b0, 100);
    chk_zero("abort");
    sweep("after_abort", 1'b0, 1'b0, 0);
    chk_stats("after_abort", 256, 256, 256, 1, 0, 0);
    step();
    chk("done_held", 64'(done), 64'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
